minterm_scanner: RTL
====================

// Module: minterm_scanner
// PURPOSE
//   Drives the X,Y,Z,K,M inputs of a 5-input combinational detector and
//   checks its S_OR response. Steps through all 32 input codes, waits a
//   settle time for each code, then samples S_OR. Builds a 32-bit
//   response map and compares every sample against an expected map.
//   Sits beside the detector as its self-test driver on the FPGA board.
// PARAMETERS
//   SETTLE_CYC  2             cycles each code is held before S_OR is sampled (>=1)
//   EXP_MAP     32'h0A3E8C5C  expected S_OR per code; bit i = response to code i
// PORTS
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous reset, active-high
//   start      in   1   one-cycle request to begin a scan
//   S_OR       in   1   detector output under test
//   X          out  1   code bit 4 (MSB)
//   Y          out  1   code bit 3
//   Z          out  1   code bit 2
//   K          out  1   code bit 1
//   M          out  1   code bit 0 (LSB)
//   busy       out  1   high while a scan is running
//   done       out  1   high from scan completion until the next start
//   map        out  32  captured S_OR values; bit i = sample for code i
//   err_cnt    out  6   count of mismatches against EXP_MAP (0..32)
//   err_flag   out  1   high when err_cnt != 0
//   first_err  out  5   code index of the first mismatch; 0 if none
// BEHAVIOUR
//   - Reset: all outputs 0, FSM = IDLE, idx = 0, settle counter = 0.
//     Takes effect immediately, including mid-scan. The partial scan is lost.
//   - Code bus: {X,Y,Z,K,M} = idx. Registered, so it changes only on a clk edge.
//   - FSM states: IDLE, SETTLE, SAMPLE, DONE.
//   - IDLE/DONE + start:
//       -> SETTLE, with idx = 0, scnt = 0.
//       Clear map, err_cnt, err_flag, first_err. done <= 0, busy <= 1.
//   - SETTLE:
//       scnt increments every cycle.
//       When scnt == SETTLE_CYC-1 -> SAMPLE.
//   - SAMPLE:
//       map[idx] <= S_OR.
//       If S_OR != EXP_MAP[idx]: err_cnt++.
//       If this is the first mismatch of the scan: first_err <= idx.
//       If idx == 31 -> DONE, busy <= 0, done <= 1.
//       Otherwise idx++, scnt = 0 -> SETTLE.
//   - Timing:
//       Each code occupies SETTLE_CYC+1 cycles.
//       done rises 32*(SETTLE_CYC+1) cycles after the start edge
//       (96 cycles at the default SETTLE_CYC).
//   - start while busy: ignored, no restart.
//   - start in DONE: begins a new scan (see IDLE/DONE + start).
//   - In DONE, idx holds at 31, so the code bus stays at 5'b11111 until the next start.
//   - err_flag is registered. It is updated in the same cycle as err_cnt.
//   - err_cnt cannot exceed 32, so no saturation logic is needed.
// CONFIGURATION
//   SCAN_HALT_EN defined:
//     On the first mismatch, the FSM goes to DONE right after that SAMPLE cycle.
//     Result: busy <= 0, done <= 1, err_cnt = 1, first_err = failing index.
//     The code bus holds the failing code.
//     map bits above the failing index stay 0.
//   SCAN_HALT_EN undefined (default):
//     The FSM always scans all 32 codes and reports the total mismatch count.
// TESTING
//   1. Correct detector model (matches EXP_MAP), start pulse:
//      -> done after 96 cycles; map = 32'h0A3E8C5C; err_cnt = 0; err_flag = 0.
//   2. S_OR tied to 0:
//      -> map = 0; err_cnt = 14; first_err = 2.
//   3. Model with code 21 inverted, SCAN_HALT_EN undefined:
//      -> err_cnt = 1; first_err = 21; map = 32'h0A1E8C5C.
//   4. Same model as scenario 3, SCAN_HALT_EN defined:
//      -> halts in DONE with {X,Y,Z,K,M} = 5'b10101;
//         err_cnt = 1; map[31:21] = 0.
//   5. start re-pulsed at cycle 40 of a scan
//      -> ignored; done still at cycle 96.
//      Then rst asserted mid-scan
//      -> busy, done, map, err_cnt, and the code bus go to 0 immediately.
//   6. SETTLE_CYC = 1, start pulse:
//      -> done after 64 cycles; S_OR is sampled one cycle after each code update.

Source files
------------

// File: rtl/minterm_scanner.sv
// minterm_scanner: self-test driver for a 5-input combinational detector.
// It steps the code bus {X,Y,Z,K,M} through all 32 codes and holds each code
// for SETTLE_CYC cycles. It then samples S_OR, records the sample in map and
// counts mismatches against EXP_MAP.
// Optional build macro SCAN_HALT_EN: when it is defined, the scan stops in
// DONE right after the first mismatching sample.
module minterm_scanner #(
  parameter int          SETTLE_CYC = 2,
  parameter logic [31:0] EXP_MAP    = 32'h0A3E8C5C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        S_OR,
  output logic        X,
  output logic        Y,
  output logic        Z,
  output logic        K,
  output logic        M,
  output logic        busy,
  output logic        done,
  output logic [31:0] map,
  output logic [5:0]  err_cnt,
  output logic        err_flag,
  output logic [4:0]  first_err
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SCNT_LAST = CW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_idx;
  logic [CW-1:0] r_scnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_map;
  logic [5:0]  r_err_cnt;
  logic        r_err_flag;
  logic [4:0]  r_first_err;

  logic w_start_scan;
  logic w_sample;
  logic w_mismatch;
  logic w_halt;

  assign w_start_scan = ((r_state == IDLE) || (r_state == DONE)) && start;
  assign w_sample     = (r_state == SAMPLE);
  assign w_mismatch   = (S_OR != EXP_MAP[r_idx]);

`ifdef SCAN_HALT_EN
  assign w_halt = w_mismatch;
`else
  assign w_halt = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: settle for SETTLE_CYC cycles, then sample once per code
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_next = SETTLE;
      SETTLE:     if (r_scnt == SCNT_LAST) w_state_next = SAMPLE;
      SAMPLE:     if ((r_idx == 5'd31) || w_halt) w_state_next = DONE;
                  else w_state_next = SETTLE;
      default:    w_state_next = IDLE;
    endcase
  end

  // Scan datapath: code index, settle counter, status and error bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_scnt      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_cnt   <= '0;
      r_err_flag  <= 1'b0;
      r_first_err <= '0;
    end else if (w_start_scan) begin
      r_idx       <= '0;
      r_scnt      <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_err_cnt   <= '0;
      r_err_flag  <= 1'b0;
      r_first_err <= '0;
    end else if (r_state == SETTLE) begin
      r_scnt <= r_scnt + 1'b1;
    end else if (w_sample) begin
      if (w_mismatch) begin
        r_err_cnt  <= r_err_cnt + 6'd1;
        r_err_flag <= 1'b1;
        // An error count of zero means this is the first mismatch of the scan
        if (r_err_cnt == 6'd0) r_first_err <= r_idx;
      end
      if (w_state_next == DONE) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_idx  <= r_idx + 5'd1;
        r_scnt <= '0;
      end
    end
  end

  // Response map: each bit is cleared at scan start and captured in its code's SAMPLE cycle
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_map
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    r_map[gi] <= 1'b0;
        else if (w_start_scan)                      r_map[gi] <= 1'b0;
        else if (w_sample && (r_idx == 5'(gi)))     r_map[gi] <= S_OR;
      end
    end
  endgenerate

  assign {X, Y, Z, K, M} = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign map       = r_map;
  assign err_cnt   = r_err_cnt;
  assign err_flag  = r_err_flag;
  assign first_err = r_first_err;

endmodule
